// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and slot address helper for sprite capture and rendering.
package sprite_pkg;

    localparam int unsigned SPRITE_FIRST_BASE = 2552896;
    localparam int unsigned SPRITE_STRIDE     = 1750;
    localparam int unsigned SPRITE_PIXELS     = 1750;
    localparam int unsigned SPRITE_SLOTS      = 3;

    typedef logic [0:0] cap_state_t;
    localparam cap_state_t StIdle    = 1'b0;
    localparam cap_state_t StCapture = 1'b1;

    function automatic int unsigned slot_base(input int unsigned first_base,
                                              input int unsigned stride,
                                              input int unsigned k);
        return first_base + k * stride;
    endfunction

endpackage

// File: rtl/sprite_slot_decode.sv
// Combinational SDRAM base address to sprite slot decoder; also used for read-side bounds checks.
module sprite_slot_decode
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = SPRITE_SLOTS,
    parameter int unsigned FIRST_BASE  = SPRITE_FIRST_BASE,
    parameter int unsigned BASE_STRIDE = SPRITE_STRIDE,
    parameter int unsigned SDRAM_AW    = 24,
    parameter int unsigned SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [SDRAM_AW-1:0] sdram_base_addr,
    output logic                hit,
    output logic [SLOT_W-1:0]   slot_idx
);

    always_comb begin
        hit      = 1'b0;
        slot_idx = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (sdram_base_addr == SDRAM_AW'(slot_base(FIRST_BASE, BASE_STRIDE, k))) begin
                hit      = 1'b1;
                slot_idx = SLOT_W'(k);
            end
        end
    end

endmodule

// File: rtl/sprite_load_ctrl.sv
// Captures sprite frames out of the SD->SDRAM pixel stream into per-slot regions of the sprite BRAM.
module sprite_load_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = SPRITE_SLOTS,
    parameter int unsigned SLOT_PIXELS = SPRITE_PIXELS,
    parameter int unsigned FIRST_BASE  = SPRITE_FIRST_BASE,
    parameter int unsigned BASE_STRIDE = SPRITE_STRIDE,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SDRAM_AW    = 24,
    parameter int unsigned BRAM_AW     = $clog2(NUM_SLOTS * SLOT_PIXELS),
    parameter int unsigned SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 pic_switch,
    input  logic [SDRAM_AW-1:0]  sdram_base_addr,
    input  logic                 sdram_wr_en,
    input  logic [DATA_W-1:0]    sdram_wr_data,
    output logic                 bram_we,
    output logic [BRAM_AW-1:0]   bram_addr,
    output logic [DATA_W-1:0]    bram_data,
    output logic                 busy,
    output logic [SLOT_W-1:0]    cur_slot,
    output logic [NUM_SLOTS-1:0] slot_loaded,
    output logic                 all_loaded,
    output logic [NUM_SLOTS-1:0] slot_short
);

    localparam int unsigned CNT_W = (SLOT_PIXELS > 1) ? $clog2(SLOT_PIXELS) : 1;

    cap_state_t           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BRAM_AW-1:0]   offset_q, offset_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [NUM_SLOTS-1:0] loaded_q, loaded_d;
    logic [NUM_SLOTS-1:0] short_q, short_d;
    logic                 we_q, we_d;
    logic [BRAM_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 last_word;
    logic                 hit;
    logic [SLOT_W-1:0]    hit_idx;

    sprite_slot_decode #(
        .NUM_SLOTS   (NUM_SLOTS),
        .FIRST_BASE  (FIRST_BASE),
        .BASE_STRIDE (BASE_STRIDE),
        .SDRAM_AW    (SDRAM_AW),
        .SLOT_W      (SLOT_W)
    ) u_decode (
        .sdram_base_addr (sdram_base_addr),
        .hit             (hit),
        .slot_idx        (hit_idx)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        offset_d  = offset_q;
        slot_d    = slot_q;
        loaded_d  = loaded_q;
        short_d   = short_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        last_word = 1'b0;

        // A new picture always wins over a pixel in the same cycle.
        if (pic_switch) begin
            if (state_q == StCapture) begin
                short_d[slot_q] = 1'b1;
            end
            if (hit) begin
                state_d           = StCapture;
                slot_d            = hit_idx;
                count_d           = '0;
                offset_d          = BRAM_AW'(32'(hit_idx) * SLOT_PIXELS);
                loaded_d[hit_idx] = 1'b0;
                short_d[hit_idx]  = 1'b0;
            end else begin
                state_d = StIdle;
            end
        end else if (state_q == StCapture && sdram_wr_en) begin
            we_d    = 1'b1;
            addr_d  = offset_q + BRAM_AW'(count_q);
            data_d  = sdram_wr_data;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(SLOT_PIXELS - 1)) begin
                last_word        = 1'b1;
                loaded_d[slot_q] = 1'b1;
                state_d          = StIdle;
            end
        end

        // Stays up through the cycle that presents the final word.
        busy_d = (state_d == StCapture) || last_word;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            offset_q <= '0;
            slot_q   <= '0;
            loaded_q <= '0;
            short_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            slot_q   <= slot_d;
            loaded_q <= loaded_d;
            short_q  <= short_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_data   = data_q;
    assign busy        = busy_q;
    assign cur_slot    = slot_q;
    assign slot_loaded = loaded_q;
    assign slot_short  = short_q;
    assign all_loaded  = &loaded_q;

endmodule

// File: tb/tb_sprite_load_ctrl.sv
// Directed self-checking bench for sprite_load_ctrl with default parameters.
module tb_sprite_load_ctrl;
    import sprite_pkg::*;

    localparam int LOG_N = 16384;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        pic_switch;
    logic [23:0] sdram_base_addr;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic        bram_we;
    logic [12:0] bram_addr;
    logic [15:0] bram_data;
    logic        busy;
    logic [1:0]  cur_slot;
    logic [2:0]  slot_loaded;
    logic        all_loaded;
    logic [2:0]  slot_short;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log filled by the monitor only.
    int          wr_cnt = 0;
    logic [12:0] log_addr [LOG_N];
    logic [15:0] got_mem  [8192];
    int          hits     [8192];

    sprite_load_ctrl dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .pic_switch      (pic_switch),
        .sdram_base_addr (sdram_base_addr),
        .sdram_wr_en     (sdram_wr_en),
        .sdram_wr_data   (sdram_wr_data),
        .bram_we         (bram_we),
        .bram_addr       (bram_addr),
        .bram_data       (bram_data),
        .busy            (busy),
        .cur_slot        (cur_slot),
        .slot_loaded     (slot_loaded),
        .all_loaded      (all_loaded),
        .slot_short      (slot_short)
    );

    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) begin
        #1;
        if (bram_we === 1'b1) begin
            if (wr_cnt < LOG_N) log_addr[wr_cnt] = bram_addr;
            got_mem[bram_addr] = bram_data;
            hits[bram_addr]    = hits[bram_addr] + 1;
            wr_cnt             = wr_cnt + 1;
        end
    end

    task automatic pulse(input logic [23:0] b, input logic we, input logic [15:0] d);
        @(negedge clk_50m);
        pic_switch = 1'b1; sdram_base_addr = b; sdram_wr_en = we; sdram_wr_data = d;
        @(negedge clk_50m);
        pic_switch = 1'b0; sdram_wr_en = 1'b0;
    endtask

    task automatic stream(input int n, input logic [15:0] start);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50m);
            sdram_wr_en = 1'b1; sdram_wr_data = start + 16'(i);
        end
        @(negedge clk_50m);
        sdram_wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pic_switch = 1'b0; sdram_base_addr = '0;
        sdram_wr_en = 1'b0; sdram_wr_data = '0;
        repeat (2) @(negedge clk_50m);
        n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bram_we); end
        n_checks++; if (bram_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bram_addr); end
        n_checks++; if (bram_data !== 16'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bram_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (cur_slot !== 2'd0) begin n_fail++; $display("FAIL reset_slot got %0d want 0", cur_slot); end
        n_checks++; if (slot_loaded !== 3'b000) begin n_fail++; $display("FAIL reset_loaded got %b want 000", slot_loaded); end
        n_checks++; if (slot_short !== 3'b000) begin n_fail++; $display("FAIL reset_short got %b want 000", slot_short); end
        n_checks++; if (all_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_all got %b want 0", all_loaded); end
        rst_n = 1'b1;
    endtask

    task automatic test_slot0;
        int snap, bad;
        snap = wr_cnt;
        pulse(24'd2552896, 1'b0, 16'h0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL s0_busy_start got %b want 1", busy); end
        n_checks++; if (cur_slot !== 2'd0) begin n_fail++; $display("FAIL s0_cur_slot got %0d want 0", cur_slot); end
        stream(1750, 16'd1);
        n_checks++; if (slot_loaded !== 3'b001 || bram_we !== 1'b1) begin
            n_fail++; $display("FAIL s0_loaded_with_last got %b/%b want 001/1", slot_loaded, bram_we); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL s0_busy_last got %b want 1", busy); end
        @(negedge clk_50m);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s0_busy_end got %b want 0", busy); end
        n_checks++; if (wr_cnt - snap !== 1750) begin n_fail++; $display("FAIL s0_count got %0d want 1750", wr_cnt - snap); end
        bad = 0;
        for (int i = 0; i < 1750; i++) if (got_mem[i] !== 16'(i + 1)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL s0_data got %0d bad words want 0", bad); end
    endtask

    task automatic test_slot2;
        int snap, bad;
        snap = wr_cnt;
        pulse(24'd2556396, 1'b0, 16'h0);
        n_checks++; if (cur_slot !== 2'd2) begin n_fail++; $display("FAIL s2_cur_slot got %0d want 2", cur_slot); end
        stream(1750, 16'hA000);
        @(negedge clk_50m);
        n_checks++; if (slot_loaded !== 3'b101) begin n_fail++; $display("FAIL s2_loaded got %b want 101", slot_loaded); end
        n_checks++; if (log_addr[snap] !== 13'd3500 || log_addr[snap + 1749] !== 13'd5249) begin
            n_fail++; $display("FAIL s2_range got %0d..%0d want 3500..5249", log_addr[snap], log_addr[snap + 1749]); end
        bad = 0;
        for (int i = 0; i < 1750; i++) if (got_mem[3500 + i] !== 16'hA000 + 16'(i)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL s2_data got %0d bad words want 0", bad); end
    endtask

    task automatic test_short;
        int snap;
        pulse(24'd2554646, 1'b0, 16'h0);
        stream(600, 16'h3000);
        pulse(24'd0, 1'b0, 16'h0);
        n_checks++; if (slot_short !== 3'b010) begin n_fail++; $display("FAIL short_bits got %b want 010", slot_short); end
        n_checks++; if (slot_loaded !== 3'b101) begin n_fail++; $display("FAIL short_loaded got %b want 101", slot_loaded); end
        n_checks++; if (busy !== 1'b0 || dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL short_idle got busy=%b state=%b want 0/0", busy, dut.state_q); end
        snap = wr_cnt;
        stream(20, 16'h3300);
        @(negedge clk_50m);
        n_checks++; if (wr_cnt - snap !== 0) begin n_fail++; $display("FAIL short_no_write got %0d want 0", wr_cnt - snap); end
    endtask

    task automatic test_oversize;
        int snap, h1750, bad;
        h1750 = hits[1750];
        pulse(24'd2552896, 1'b0, 16'h0);
        snap = wr_cnt;
        stream(1800, 16'd1);
        @(negedge clk_50m);
        n_checks++; if (wr_cnt - snap !== 1750) begin n_fail++; $display("FAIL over_count got %0d want 1750", wr_cnt - snap); end
        n_checks++; if (log_addr[wr_cnt - 1] !== 13'd1749) begin
            n_fail++; $display("FAIL over_last_addr got %0d want 1749", log_addr[wr_cnt - 1]); end
        n_checks++; if (hits[1750] !== h1750) begin n_fail++; $display("FAIL over_spill got %0d want %0d", hits[1750], h1750); end
        bad = 0;
        for (int i = 0; i < 1750; i++) if (got_mem[i] !== 16'(i + 1)) bad++;
        n_checks++; if (bad !== 0 || slot_loaded !== 3'b101) begin
            n_fail++; $display("FAIL over_data got %0d bad, loaded %b want 0, 101", bad, slot_loaded); end
    endtask

    task automatic test_same_cycle;
        int snap;
        snap = wr_cnt;
        pulse(24'd2554646, 1'b1, 16'hDEAD);
        n_checks++; if (wr_cnt - snap !== 0) begin n_fail++; $display("FAIL same_dropped got %0d writes want 0", wr_cnt - snap); end
        stream(1750, 16'h5000);
        @(negedge clk_50m);
        n_checks++; if (log_addr[snap] !== 13'd1750 || got_mem[1750] !== 16'h5000) begin
            n_fail++; $display("FAIL same_first got %0d/%h want 1750/5000", log_addr[snap], got_mem[1750]); end
        n_checks++; if (wr_cnt - snap !== 1750) begin n_fail++; $display("FAIL same_count got %0d want 1750", wr_cnt - snap); end
        n_checks++; if (slot_loaded !== 3'b111 || all_loaded !== 1'b1) begin
            n_fail++; $display("FAIL all_loaded got %b/%b want 111/1", slot_loaded, all_loaded); end
    endtask

    task automatic test_reset_mid;
        int snap;
        pulse(24'd2556396, 1'b0, 16'h0);
        stream(100, 16'h7000);
        n_checks++; if (slot_loaded !== 3'b011) begin n_fail++; $display("FAIL mid_reload got %b want 011", slot_loaded); end
        @(negedge clk_50m);
        sdram_wr_en = 1'b1; sdram_wr_data = 16'h7777;
        @(negedge clk_50m);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bram_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_we_busy got %b/%b want 0/0", bram_we, busy); end
        n_checks++; if (bram_addr !== 13'd0 || bram_data !== 16'd0) begin
            n_fail++; $display("FAIL mid_addr_data got %0d/%h want 0/0", bram_addr, bram_data); end
        n_checks++; if (cur_slot !== 2'd0 || slot_loaded !== 3'b000) begin
            n_fail++; $display("FAIL mid_slot_loaded got %0d/%b want 0/000", cur_slot, slot_loaded); end
        n_checks++; if (slot_short !== 3'b000 || all_loaded !== 1'b0) begin
            n_fail++; $display("FAIL mid_short_all got %b/%b want 000/0", slot_short, all_loaded); end
        @(negedge clk_50m);
        sdram_wr_en = 1'b0; rst_n = 1'b1;
        @(negedge clk_50m);
        n_checks++; if (dut.state_q !== StIdle) begin n_fail++; $display("FAIL mid_state got %b want 0", dut.state_q); end
        snap = wr_cnt;
        stream(10, 16'h7100);
        @(negedge clk_50m);
        n_checks++; if (wr_cnt - snap !== 0) begin n_fail++; $display("FAIL mid_no_write got %0d want 0", wr_cnt - snap); end
    endtask

    initial begin
        test_reset();
        test_slot0();
        test_slot2();
        test_short();
        test_oversize();
        test_same_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
